// File: rtl/bd_cpld_recv_if.sv
// Stream bundle for the BD completion receiver: RC completions in, realigned BDs out.
interface bd_cpld_recv_if;
  logic         axis_rc_tvalid;
  logic         axis_rc_tready;
  logic [255:0] axis_rc_tdata;
  logic         axis_rc_tlast;
  logic         axis_bd_out_tvalid;
  logic         axis_bd_out_tready;
  logic [255:0] axis_bd_out_tdata;
  logic         axis_bd_out_tlast;

  modport master (
    output axis_rc_tvalid,
    input  axis_rc_tready,
    output axis_rc_tdata,
    output axis_rc_tlast,
    input  axis_bd_out_tvalid,
    output axis_bd_out_tready,
    input  axis_bd_out_tdata,
    input  axis_bd_out_tlast
  );

  modport slave (
    input  axis_rc_tvalid,
    output axis_rc_tready,
    input  axis_rc_tdata,
    input  axis_rc_tlast,
    output axis_bd_out_tvalid,
    input  axis_bd_out_tready,
    output axis_bd_out_tdata,
    output axis_bd_out_tlast
  );
endinterface

// File: rtl/bd_cpld_recv.sv
// BD fetch completion receiver: checks CplD tag order/status, strips the 3-DW header and
// repacks the payload into one 32-byte BD per output beat.
module bd_cpld_recv (
  input  logic          user_clk,
  input  logic          user_reset,
  input  logic          cpld_start,
  input  logic [3:0]    bd_size_for_cpld,
  input  logic [1:0]    cpld_max_req_num,
  bd_cpld_recv_if.slave bus,
  output logic          cpld_done,
  output logic          cpld_err
);
  typedef enum logic [2:0] {StIdle, StWaitDesc, StData, StDrain, StDiscard} state_e;

  state_e      state_q;
  logic [31:0] acc_q [16];
  logic [31:0] acc_d [16];
  logic [4:0]  acc_cnt_q, acc_cnt_d;
  logic [8:0]  exp_dw_q, dw_rcvd_q;
  logic [3:0]  last_bd_q, bd_cnt_q;
  logic [1:0]  last_idx_q;
  logic [2:0]  tag_idx_q;
  logic [10:0] rem_q;
  logic        req_cmpl_q;

  logic        in_recv, first, accept, bd_hs, desc_bad, beat_err, append, cmpl_bit;
  logic [10:0] dw_count, cur_rem, rem_next;
  logic [3:0]  lim, take, n_app;
  logic [8:0]  room, rcvd_next;
  logic [4:0]  base, slot;
  logic [255:0] shifted;
  logic [31:0] new_dw [8];

  assign in_recv = (state_q == StWaitDesc) || (state_q == StData);
  assign first   = (state_q == StWaitDesc);

  assign bus.axis_rc_tready     = (in_recv && acc_cnt_q < 5'd8) || (state_q == StDiscard);
  assign bus.axis_bd_out_tvalid = (in_recv || state_q == StDrain) && acc_cnt_q >= 5'd8;
  assign bus.axis_bd_out_tlast  = bus.axis_bd_out_tvalid && (bd_cnt_q == last_bd_q);

  assign accept = bus.axis_rc_tvalid && bus.axis_rc_tready;
  assign bd_hs  = bus.axis_bd_out_tvalid && bus.axis_bd_out_tready;

  always_comb begin
    bus.axis_bd_out_tdata = '0;
    for (int i = 0; i < 8; i++) bus.axis_bd_out_tdata[32*i +: 32] = acc_q[i];
  end

  // Segment bookkeeping: a header beat carries at most 5 payload DW, others 8.
  always_comb begin
    dw_count  = bus.axis_rc_tdata[42:32];
    room      = exp_dw_q - dw_rcvd_q;
    desc_bad  = (bus.axis_rc_tdata[45:43] != 3'd0) ||
                (bus.axis_rc_tdata[65:64] != tag_idx_q[1:0]) ||
                (tag_idx_q > {1'b0, last_idx_q}) ||
                (dw_count == 11'd0) || (dw_count > {2'b00, room});
    cur_rem   = first ? dw_count : rem_q;
    lim       = first ? 4'd5 : 4'd8;
    take      = (cur_rem < {7'd0, lim}) ? cur_rem[3:0] : lim;
    rem_next  = cur_rem - {7'd0, take};
    beat_err  = (first && desc_bad) || ((rem_next == 11'd0) != bus.axis_rc_tlast);
    append    = accept && in_recv && !beat_err;
    cmpl_bit  = first ? bus.axis_rc_tdata[30] : req_cmpl_q;
    rcvd_next = dw_rcvd_q + {5'd0, take};
    shifted   = first ? (bus.axis_rc_tdata >> 96) : bus.axis_rc_tdata;
    for (int i = 0; i < 8; i++) new_dw[i] = shifted[32*i +: 32];
  end

  // Pop first, then append behind whatever survives the pop.
  always_comb begin
    acc_d     = acc_q;
    acc_cnt_d = acc_cnt_q;
    n_app     = append ? take : 4'd0;
    slot      = '0;
    if (bd_hs) begin
      for (int i = 0; i < 8; i++) begin
        acc_d[i]   = acc_q[i+8];
        acc_d[i+8] = '0;
      end
      acc_cnt_d = acc_cnt_q - 5'd8;
    end
    base = acc_cnt_d;
    for (int i = 0; i < 8; i++) begin
      slot = base + 5'(i);
      if (4'(i) < n_app && !slot[4]) acc_d[slot[3:0]] = new_dw[i];
    end
    acc_cnt_d = acc_cnt_d + {1'b0, n_app};
  end

  always_ff @(posedge user_clk or posedge user_reset) begin
    if (user_reset) begin
      state_q    <= StIdle;
      acc_q      <= '{default: '0};
      acc_cnt_q  <= '0;
      exp_dw_q   <= '0;
      dw_rcvd_q  <= '0;
      last_bd_q  <= '0;
      bd_cnt_q   <= '0;
      last_idx_q <= '0;
      tag_idx_q  <= '0;
      rem_q      <= '0;
      req_cmpl_q <= 1'b0;
      cpld_done  <= 1'b0;
      cpld_err   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_cnt_q <= acc_cnt_d;
      cpld_done <= bd_hs && bus.axis_bd_out_tlast;
      if (bd_hs) bd_cnt_q <= bd_cnt_q + 4'd1;

      unique case (state_q)
        StIdle: begin
          if (cpld_start) begin
            exp_dw_q   <= 9'({5'(bd_size_for_cpld) + 5'd1, 3'b000});
            last_bd_q  <= bd_size_for_cpld;
            last_idx_q <= cpld_max_req_num;
            tag_idx_q  <= '0;
            dw_rcvd_q  <= '0;
            bd_cnt_q   <= '0;
            acc_cnt_q  <= '0;
            cpld_err   <= 1'b0;
            state_q    <= StWaitDesc;
          end
        end
        StWaitDesc, StData: begin
          if (accept) begin
            if (beat_err) begin
              cpld_err  <= 1'b1;
              acc_cnt_q <= '0;
              state_q   <= bus.axis_rc_tlast ? StIdle : StDiscard;
            end else begin
              dw_rcvd_q  <= rcvd_next;
              rem_q      <= rem_next;
              req_cmpl_q <= cmpl_bit;
              if (rem_next == 11'd0) begin
                // A split completion leaves the sub-request index in place.
                if (cmpl_bit) tag_idx_q <= tag_idx_q + 3'd1;
                state_q <= (rcvd_next == exp_dw_q) ? StDrain : StWaitDesc;
              end else begin
                state_q <= StData;
              end
            end
          end
        end
        StDrain: begin
          if (bd_hs && bus.axis_bd_out_tlast) state_q <= StIdle;
        end
        StDiscard: begin
          if (accept && bus.axis_rc_tlast) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_bd_cpld_recv.sv
// Self-checking bench for bd_cpld_recv: payload DWs are generated up front and every BD is
// expected to be the next 8 of them in send order.
module tb_bd_cpld_recv;
  logic       user_clk;
  logic       user_reset;
  logic       cpld_start;
  logic [3:0] bd_size;
  logic [1:0] max_req;
  logic       cpld_done;
  logic       cpld_err;

  bd_cpld_recv_if bus ();

  bd_cpld_recv dut (
    .user_clk         (user_clk),
    .user_reset       (user_reset),
    .cpld_start       (cpld_start),
    .bd_size_for_cpld (bd_size),
    .cpld_max_req_num (max_req),
    .bus              (bus),
    .cpld_done        (cpld_done),
    .cpld_err         (cpld_err)
  );

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int stab_viol = 0;
  int src_idx = 0;
  bit stall = 1'b0;
  bit tx_done = 1'b0;
  logic [31:0]  exp_dws[$];
  logic [255:0] bd_q[$];
  bit           last_q[$];
  bit           prev_hold = 1'b0;
  logic [255:0] prev_data;

  initial begin
    user_clk = 1'b0;
    forever #5 user_clk = ~user_clk;
  end

  always begin
    @(posedge user_clk);
    #1;
    bus.axis_bd_out_tready = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  always @(negedge user_clk) begin
    if (user_reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold && (bus.axis_bd_out_tvalid !== 1'b1 || bus.axis_bd_out_tdata !== prev_data))
        stab_viol++;
      if (bus.axis_bd_out_tvalid && bus.axis_bd_out_tready) begin
        bd_q.push_back(bus.axis_bd_out_tdata);
        last_q.push_back(bus.axis_bd_out_tlast);
      end
      prev_hold = bus.axis_bd_out_tvalid && !bus.axis_bd_out_tready;
      prev_data = bus.axis_bd_out_tdata;
      if (cpld_done) done_cnt++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  function automatic logic [255:0] model_bd(input int k);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = exp_dws[8*k + i];
    return r;
  endfunction

  task automatic fill(input int n);
    exp_dws.delete();
    for (int i = 0; i < n; i++) exp_dws.push_back($urandom);
  endtask

  task automatic start_fetch(input int size, input int mreq);
    bd_q.delete();
    last_q.delete();
    done_cnt = 0;
    src_idx = 0;
    cpld_start = 1'b1;
    bd_size = 4'(size);
    max_req = 2'(mreq);
    @(posedge user_clk);
    #1;
    cpld_start = 1'b0;
  endtask

  task automatic drive_beat(input logic [255:0] d, input bit last);
    int w;
    w = 0;
    bus.axis_rc_tvalid = 1'b1;
    bus.axis_rc_tdata = d;
    bus.axis_rc_tlast = last;
    @(negedge user_clk);
    while (!bus.axis_rc_tready && w < 1000) begin
      @(negedge user_clk);
      w++;
    end
    if (w >= 1000) begin
      checks++;
      failures++;
      $display("FAIL rc_accept_timeout: tready low for %0d cycles, required 1", w);
    end
    @(posedge user_clk);
    #1;
    bus.axis_rc_tvalid = 1'b0;
    bus.axis_rc_tlast = 1'b0;
    if ($urandom_range(0, 3) == 0) begin
      @(posedge user_clk);
      #1;
    end
  endtask

  // cut != 0 stops after that many beats, with tlast forced to cut_tlast on the final one.
  task automatic send_tlp(input int tag, input int dwc, input int status, input bit cmpl,
                          input int cut, input bit cut_tlast);
    logic [255:0] d;
    int left, take, beat;
    bit last;
    d = '0;
    d[42:32] = 11'(dwc);
    d[45:43] = 3'(status);
    d[71:64] = 8'(tag);
    d[30] = cmpl;
    left = dwc;
    take = (left < 5) ? left : 5;
    for (int i = 0; i < take; i++) begin
      d[96 + 32*i +: 32] = exp_dws[src_idx];
      src_idx++;
    end
    left -= take;
    beat = 1;
    last = (left == 0);
    if (cut == 1) last = cut_tlast;
    drive_beat(d, last);
    while (left > 0 && !(cut != 0 && beat >= cut)) begin
      d = '0;
      take = (left < 8) ? left : 8;
      for (int i = 0; i < take; i++) begin
        d[32*i +: 32] = exp_dws[src_idx];
        src_idx++;
      end
      left -= take;
      beat++;
      last = (left == 0);
      if (cut != 0 && beat == cut) last = cut_tlast;
      drive_beat(d, last);
    end
  endtask

  task automatic wait_bds(input int n, output bit ok);
    int w;
    w = 0;
    while ((bd_q.size() < n || done_cnt == 0) && w < 4000) begin
      @(negedge user_clk);
      w++;
    end
    ok = (w < 4000);
    repeat (3) @(negedge user_clk);
    @(posedge user_clk);
    #1;
  endtask

  task automatic test_reset();
    user_reset = 1'b1;
    cpld_start = 1'b0;
    bd_size = '0;
    max_req = '0;
    bus.axis_rc_tvalid = 1'b0;
    bus.axis_rc_tdata = '0;
    bus.axis_rc_tlast = 1'b0;
    repeat (3) @(posedge user_clk);
    #1;
    checks++; if (bus.axis_rc_tready !== 1'b0) begin failures++;
      $display("FAIL reset_rc_tready: got %0b, required 0", bus.axis_rc_tready); end
    checks++; if (bus.axis_bd_out_tvalid !== 1'b0) begin failures++;
      $display("FAIL reset_bd_tvalid: got %0b, required 0", bus.axis_bd_out_tvalid); end
    checks++; if (bus.axis_bd_out_tlast !== 1'b0) begin failures++;
      $display("FAIL reset_bd_tlast: got %0b, required 0", bus.axis_bd_out_tlast); end
    checks++; if (cpld_done !== 1'b0) begin failures++;
      $display("FAIL reset_done: got %0b, required 0", cpld_done); end
    checks++; if (cpld_err !== 1'b0) begin failures++;
      $display("FAIL reset_err: got %0b, required 0", cpld_err); end
    user_reset = 1'b0;
    repeat (2) @(posedge user_clk);
    #1;
    checks++; if (bus.axis_rc_tready !== 1'b0) begin failures++;
      $display("FAIL idle_rc_tready: got %0b, required 0", bus.axis_rc_tready); end
  endtask

  task automatic test_single();
    bit ok;
    start_fetch(0, 0);
    fill(8);
    send_tlp(0, 8, 0, 1'b1, 0, 1'b0);
    wait_bds(1, ok);
    checks++; if (!ok) begin failures++;
      $display("FAIL single_timeout: bds=%0d done=%0d, required 1 and 1", bd_q.size(), done_cnt); end
    checks++; if (bd_q.size() != 1) begin failures++;
      $display("FAIL single_count: got %0d BDs, required 1", bd_q.size()); end
    for (int k = 0; k < bd_q.size() && k < 1; k++) begin
      checks++;
      if (bd_q[k] !== model_bd(k) || last_q[k] !== 1'b1) begin failures++;
        $display("FAIL single_bd%0d: got %h last=%0b, required %h last=1", k, bd_q[k], last_q[k],
                 model_bd(k)); end
    end
    checks++; if (done_cnt != 1) begin failures++;
      $display("FAIL single_done: got %0d pulses, required 1", done_cnt); end
    checks++; if (cpld_err !== 1'b0) begin failures++;
      $display("FAIL single_err: got %0b, required 0", cpld_err); end
  endtask

  task automatic test_four_sub();
    bit ok;
    start_fetch(15, 3);
    fill(128);
    send_tlp(0, 8, 0, 1'b1, 0, 1'b0);
    send_tlp(1, 32, 0, 1'b1, 0, 1'b0);
    send_tlp(2, 32, 0, 1'b1, 0, 1'b0);
    send_tlp(3, 56, 0, 1'b1, 0, 1'b0);
    wait_bds(16, ok);
    checks++; if (!ok) begin failures++;
      $display("FAIL four_timeout: bds=%0d done=%0d, required 16 and 1", bd_q.size(), done_cnt); end
    checks++; if (bd_q.size() != 16) begin failures++;
      $display("FAIL four_count: got %0d BDs, required 16", bd_q.size()); end
    for (int k = 0; k < bd_q.size() && k < 16; k++) begin
      checks++;
      if (bd_q[k] !== model_bd(k) || last_q[k] !== (k == 15)) begin failures++;
        $display("FAIL four_bd%0d: got %h last=%0b, required %h last=%0b", k, bd_q[k], last_q[k],
                 model_bd(k), (k == 15)); end
    end
    checks++; if (done_cnt != 1) begin failures++;
      $display("FAIL four_done: got %0d pulses, required 1", done_cnt); end
    checks++; if (cpld_err !== 1'b0) begin failures++;
      $display("FAIL four_err: got %0b, required 0", cpld_err); end
  endtask

  task automatic test_split();
    bit ok;
    start_fetch(3, 0);
    fill(32);
    send_tlp(0, 16, 0, 1'b0, 0, 1'b0);
    send_tlp(0, 16, 0, 1'b1, 0, 1'b0);
    wait_bds(4, ok);
    checks++; if (!ok) begin failures++;
      $display("FAIL split_timeout: bds=%0d done=%0d, required 4 and 1", bd_q.size(), done_cnt); end
    checks++; if (bd_q.size() != 4) begin failures++;
      $display("FAIL split_count: got %0d BDs, required 4", bd_q.size()); end
    for (int k = 0; k < bd_q.size() && k < 4; k++) begin
      checks++;
      if (bd_q[k] !== model_bd(k) || last_q[k] !== (k == 3)) begin failures++;
        $display("FAIL split_bd%0d: got %h last=%0b, required %h last=%0b", k, bd_q[k], last_q[k],
                 model_bd(k), (k == 3)); end
    end
    checks++; if (cpld_err !== 1'b0) begin failures++;
      $display("FAIL split_err: got %0b, required 0", cpld_err); end
  endtask

  task automatic test_backpressure();
    bit ok;
    int w;
    start_fetch(7, 1);
    fill(64);
    stall = 1'b1;
    tx_done = 1'b0;
    fork
      begin
        send_tlp(0, 32, 0, 1'b1, 0, 1'b0);
        send_tlp(1, 32, 0, 1'b1, 0, 1'b0);
        tx_done = 1'b1;
      end
    join_none
    repeat (20) @(negedge user_clk);
    checks++; if (bus.axis_rc_tready !== 1'b0) begin failures++;
      $display("FAIL bp_rc_tready: got %0b while stalled, required 0", bus.axis_rc_tready); end
    checks++; if (bus.axis_bd_out_tvalid !== 1'b1) begin failures++;
      $display("FAIL bp_bd_tvalid: got %0b while stalled, required 1", bus.axis_bd_out_tvalid); end
    stall = 1'b0;
    wait_bds(8, ok);
    w = 0;
    while (!tx_done && w < 200) begin
      @(posedge user_clk);
      #1;
      w++;
    end
    checks++; if (!ok || !tx_done) begin failures++;
      $display("FAIL bp_timeout: bds=%0d sent=%0b, required 8 and 1", bd_q.size(), tx_done); end
    checks++; if (bd_q.size() != 8) begin failures++;
      $display("FAIL bp_count: got %0d BDs, required 8", bd_q.size()); end
    for (int k = 0; k < bd_q.size() && k < 8; k++) begin
      checks++;
      if (bd_q[k] !== model_bd(k) || last_q[k] !== (k == 7)) begin failures++;
        $display("FAIL bp_bd%0d: got %h last=%0b, required %h last=%0b", k, bd_q[k], last_q[k],
                 model_bd(k), (k == 7)); end
    end
    checks++; if (stab_viol != 0) begin failures++;
      $display("FAIL bp_stable: %0d output changes while stalled, required 0", stab_viol); end
    checks++; if (done_cnt != 1) begin failures++;
      $display("FAIL bp_done: got %0d pulses, required 1", done_cnt); end
  endtask

  task automatic test_errors();
    bit ok;
    string nm;
    for (int e = 0; e < 3; e++) begin
      nm = (e == 0) ? "err_tag" : (e == 1) ? "err_status" : "err_early_tlast";
      start_fetch(1, 0);
      fill(16);
      if (e == 0) send_tlp(1, 16, 0, 1'b1, 0, 1'b0);
      else if (e == 1) send_tlp(0, 16, 1, 1'b1, 0, 1'b0);
      else send_tlp(0, 16, 0, 1'b1, 2, 1'b1);
      repeat (10) @(posedge user_clk);
      #1;
      checks++; if (cpld_err !== 1'b1) begin failures++;
        $display("FAIL %s_flag: cpld_err=%0b, required 1", nm, cpld_err); end
      checks++; if (bd_q.size() != 0 || done_cnt != 0) begin failures++;
        $display("FAIL %s_output: bds=%0d done=%0d, required 0 and 0", nm, bd_q.size(),
                 done_cnt); end
      checks++; if (bus.axis_rc_tready !== 1'b0) begin failures++;
        $display("FAIL %s_idle: rc_tready=%0b, required 0", nm, bus.axis_rc_tready); end
      start_fetch(1, 0);
      checks++; if (cpld_err !== 1'b0) begin failures++;
        $display("FAIL %s_clear: cpld_err=%0b after start, required 0", nm, cpld_err); end
      fill(16);
      send_tlp(0, 16, 0, 1'b1, 0, 1'b0);
      wait_bds(2, ok);
      checks++;
      if (!ok || bd_q.size() != 2 || bd_q[0] !== model_bd(0) || bd_q[1] !== model_bd(1)) begin
        failures++;
        $display("FAIL %s_recover: bds=%0d ok=%0b, required 2 matching BDs", nm, bd_q.size(), ok);
      end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    start_fetch(3, 0);
    fill(32);
    stall = 1'b1;
    send_tlp(0, 32, 0, 1'b1, 2, 1'b0);
    checks++; if (bus.axis_bd_out_tvalid !== 1'b1) begin failures++;
      $display("FAIL arst_pre_valid: got %0b, required 1", bus.axis_bd_out_tvalid); end
    @(negedge user_clk);
    #2;
    user_reset = 1'b1;
    #1;
    checks++; if (bus.axis_bd_out_tvalid !== 1'b0 || bus.axis_bd_out_tlast !== 1'b0) begin
      failures++;
      $display("FAIL arst_bd: tvalid=%0b tlast=%0b, required 0 0", bus.axis_bd_out_tvalid,
               bus.axis_bd_out_tlast); end
    checks++; if (bus.axis_rc_tready !== 1'b0) begin failures++;
      $display("FAIL arst_rc_tready: got %0b, required 0", bus.axis_rc_tready); end
    checks++; if (cpld_done !== 1'b0 || cpld_err !== 1'b0) begin failures++;
      $display("FAIL arst_flags: done=%0b err=%0b, required 0 0", cpld_done, cpld_err); end
    @(posedge user_clk);
    #1;
    user_reset = 1'b0;
    stall = 1'b0;
    start_fetch(3, 0);
    fill(32);
    send_tlp(0, 32, 0, 1'b1, 0, 1'b0);
    wait_bds(4, ok);
    checks++; if (!ok || bd_q.size() != 4 || done_cnt != 1) begin failures++;
      $display("FAIL arst_after: bds=%0d done=%0d, required 4 and 1", bd_q.size(), done_cnt); end
    for (int k = 0; k < bd_q.size() && k < 4; k++) begin
      checks++;
      if (bd_q[k] !== model_bd(k) || last_q[k] !== (k == 3)) begin failures++;
        $display("FAIL arst_bd%0d: got %h, required %h", k, bd_q[k], model_bd(k)); end
    end
  endtask

  task automatic test_random();
    bit ok;
    for (int it = 0; it < 8; it++) begin
      int size, mreq, total, remn, part, a;
      size = $urandom_range(0, 15);
      mreq = $urandom_range(0, 3);
      total = (size + 1) * 8;
      start_fetch(size, mreq);
      fill(total);
      remn = total;
      for (int t = 0; t <= mreq; t++) begin
        part = (t == mreq) ? remn : $urandom_range(1, remn - (mreq - t));
        remn -= part;
        if (part >= 2 && $urandom_range(0, 1) == 1) begin
          a = $urandom_range(1, part - 1);
          send_tlp(t, a, 0, 1'b0, 0, 1'b0);
          send_tlp(t, part - a, 0, 1'b1, 0, 1'b0);
        end else begin
          send_tlp(t, part, 0, 1'b1, 0, 1'b0);
        end
      end
      wait_bds(size + 1, ok);
      checks++; if (!ok || bd_q.size() != size + 1) begin failures++;
        $display("FAIL rand%0d_count: got %0d BDs, required %0d", it, bd_q.size(), size + 1); end
      for (int k = 0; k < bd_q.size() && k <= size; k++) begin
        checks++;
        if (bd_q[k] !== model_bd(k) || last_q[k] !== (k == size)) begin failures++;
          $display("FAIL rand%0d_bd%0d: got %h last=%0b, required %h last=%0b", it, k, bd_q[k],
                   last_q[k], model_bd(k), (k == size)); end
      end
      checks++; if (done_cnt != 1 || cpld_err !== 1'b0) begin failures++;
        $display("FAIL rand%0d_status: done=%0d err=%0b, required 1 0", it, done_cnt, cpld_err); end
    end
  endtask

  initial begin
    bus.axis_bd_out_tready = 1'b0;
    test_reset();
    test_single();
    test_four_sub();
    test_split();
    test_backpressure();
    test_errors();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bd_cpld_recv.md
# bd_cpld_recv

Completion receiver for BD fetches in the multi-channel PCIe DMA engine. It sits on the requester-completion (RC) AXI-Stream path opposite the BD request generator, which splits one BD read into up to four non-posted reads with tag[1:0] = sub-request index. This block accepts the matching CplD TLPs, checks tag order and status, and strips the 3-DW descriptor. It realigns the payload into one 32-byte BD per output beat toward the BD buffer.

## Interface
Parameters: none; widths are fixed: 256-bit data, 32-byte BD, 4 sub-requests.

Ports:
- user_clk  in  1  clock.
- user_reset  in  1  reset. Asynchronous and active-high.
- cpld_start  in  1  one-cycle pulse that arms a new BD fetch. Honoured only in IDLE.
- bd_size_for_cpld  in  4  number of 32-byte units expected, minus 1. Sampled on cpld_start.
- cpld_max_req_num  in  2  index of the last sub-request, 0..3. Sampled on cpld_start.
- axis_rc_tvalid  in  1  completion beat valid.
- axis_rc_tready  out  1  completion beat accept.
- axis_rc_tdata  in  256  completion beat.
- axis_rc_tlast  in  1  last beat of a TLP.
- axis_bd_out_tvalid  out  1  BD valid.
- axis_bd_out_tready  in  1  BD accept.
- axis_bd_out_tdata  out  256  one BD, DW0 in [31:0].
- axis_bd_out_tlast  out  1  final BD of the fetch.
- cpld_done  out  1  one-cycle pulse on the final BD handshake.
- cpld_err  out  1  sticky error flag. Cleared by cpld_start or reset.

## Operation
- Descriptor fields, taken from the first beat of each TLP: dword_count = [42:32], status = [45:43], tag = [71:64], request_completed = [30]. Payload on the first beat is DW0..4 in [255:96]. Payload on continuation beats is DW0..7 in [255:0].
- On cpld_start:
  - latch exp_dw = (bd_size_for_cpld+1)*8 (9 bits, range 8..128), exp_units = bd_size_for_cpld + 1, last_idx = cpld_max_req_num;
  - clear tag_idx, acc_cnt and cpld_err.
- States:
  - IDLE: wait for cpld_start, then go to WAIT_DESC.
  - WAIT_DESC: on an accepted beat, check the descriptor. Error conditions are status≠0, tag[1:0]≠tag_idx, dword_count=0, or dword_count > exp_dw − dw_received. On error, set cpld_err and go to DISCARD; if that beat has tlast, go straight to IDLE. Otherwise append min(dword_count,5) DW and set rem = dword_count − appended. If rem=0, tlast is required (missing tlast is an error); if rem>0, go to DATA.
  - DATA: each accepted beat appends min(rem,8) DW. tlast must coincide with rem reaching 0; a mismatch is an error. When rem=0 and tlast: increment tag_idx if request_completed=1 (a split completion keeps the index). Then go to DRAIN if all exp_dw have been received, else back to WAIT_DESC.
  - DRAIN: go to IDLE after the BD handshake with axis_bd_out_tlast.
  - DISCARD: axis_rc_tready=1. Drop beats until tlast, then go to IDLE. No BD output; buffered DW are flushed.
- Accumulator:
  - 16-DW buffer with a 5-bit acc_cnt.
  - axis_bd_out_tvalid = (acc_cnt ≥ 8) in WAIT_DESC, DATA and DRAIN; tdata = acc[7:0].
  - A BD handshake shifts out 8 DW. Pop and append in the same cycle are allowed: new acc_cnt = acc_cnt − 8 + n, and appended DW land after the remaining ones.
- axis_bd_out_tlast = 1 on the BD whose index equals exp_units−1. A BD counter of 4 bits tracks this.
- A tag_idx beyond last_idx on a new descriptor is an error.

## Timing
- Reset values: axis_rc_tready=0, axis_bd_out_tvalid=0, axis_bd_out_tlast=0, cpld_done=0, cpld_err=0. State is IDLE; all counters are 0.
- axis_rc_tready = (acc_cnt < 8) in WAIT_DESC and DATA, 1 in DISCARD, 0 otherwise. This is combinational from registered state.
- Latency: data accepted in cycle N that completes a BD makes axis_bd_out_tvalid high in cycle N+1.
- Output holds tdata and tvalid stable while tready is low.
- cpld_done is registered: high in the cycle after the final BD handshake.
- cpld_start outside IDLE is ignored.
- Reset mid-fetch aborts immediately with no done pulse.

## Test plan
- Single unit, aligned:
  - Stimulus: bd_size_for_cpld=0, max_req_num=0; one CplD with dword_count=8, tag=0, in 2 beats (5+3 DW).
  - Required response: one BD with DW0..7 in order, tlast=1, cpld_done pulse, cpld_err=0.
- Four sub-requests:
  - Stimulus: size=15, max_req=3; tags 0..3 carrying 8, 32, 32, 56 DW.
  - Required response: 16 BDs, tlast only on the 16th, data contiguous across TLP boundaries.
- Split completion:
  - Stimulus: tag 0 delivered as two 16-DW CplDs; the first has request_completed=0, the second has 1.
  - Required response: tag_idx holds after the first, then advances; 4 BDs output.
- Backpressure:
  - Stimulus: axis_bd_out_tready low for 20 cycles mid-fetch.
  - Required response: axis_rc_tready drops once acc_cnt≥8; no DW lost or duplicated; tdata stable while stalled.
- Errors, each run separately:
  - Stimulus: tag=1 when 0 is expected; status=3'b001; an early tlast.
  - Required response: cpld_err=1, remaining beats are dropped through tlast, return to IDLE, no cpld_done. The next cpld_start clears cpld_err.
- Asynchronous reset asserted mid-DATA:
  - Required response: all outputs go to their reset values without a clock edge. A following fetch completes normally.
